pixel_blend_pipe: RTL
=====================

Name: pixel_blend_pipe

Overview:
- Pipelined, parametrised successor to the combinational per-component colour blender.
- Blends a background and a foreground pixel of NUM_CH channels, each COMP_W bits, using a per-pixel ALPHA_W-bit alpha code and a per-pixel blend mode.
- Two-stage registered pipeline with valid/ready handshake on both sides.
- Sits between the layer compositor's pixel fetch and the scan-out line buffer, so downstream stalls propagate back without data loss.

Parameters:
- COMP_W, 4, bits per colour component.
- NUM_CH, 3, channels per pixel; channel 0 occupies the LSBs.
- ALPHA_W, 3, alpha code width; AMAX = 2^ALPHA_W - 1.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  block can accept an input this cycle.
- i_bg_color  in  NUM_CH*COMP_W  background pixel.
- i_fg_color  in  NUM_CH*COMP_W  foreground pixel.
- i_fg_alpha  in  ALPHA_W  foreground alpha code.
- i_mode  in  2  blend mode: 0 BLEND, 1 ADD, 2 REPLACE, 3 MULTIPLY.
- o_valid  out  1  output pixel valid.
- i_ready  in  1  downstream accepts the output pixel.
- o_color  out  NUM_CH*COMP_W  blended pixel.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: both stage-valid flags clear; o_valid=0; o_color=0. Data registers are reset to 0.
- Reset asserted mid-operation discards all in-flight pixels. The first input accepted after release emerges normally.
- Transfers:
  - An input transfer occurs when i_valid & o_ready.
  - An output transfer occurs when o_valid & i_ready.
- Stall logic:
  - en2 = !v2 | i_ready
  - en1 = !v1 | en2
  - o_ready = en1 (combinational from i_ready; no registered skid).
- Latency: 2 cycles from input transfer to o_valid with no stall. Throughput is 1 pixel/clock while i_ready=1.
- While stalled, v1, v2 and all data registers hold, and o_color stays stable while o_valid=1 and i_ready=0.
- Stage 1 (en1):
  - Registers mode, weight w and per-channel products.
  - Weight: w = (a == AMAX) ? 2^ALPHA_W : a, so a=0 gives pure bg and a=AMAX gives pure fg exactly.
  - Products: pf = fg*w and pb = bg*(2^ALPHA_W - w), each COMP_W+ALPHA_W+1 bits.
  - Multiply product: pm = bg*(fg+1), 2*COMP_W+1 bits.
  - v1 <= i_valid & o_ready.
- Stage 2 (en2): per channel, with CMAX = 2^COMP_W - 1:
  - BLEND: (pf + pb) >> ALPHA_W, truncating. The result never exceeds CMAX.
  - ADD: min(bg + (pf >> ALPHA_W), CMAX), saturating. bg is carried from stage 1.
  - REPLACE: a != 0 ? fg : bg.
  - MULTIPLY: pm >> COMP_W. Alpha is ignored. White fg is the identity.
  - v2 <= v1 when en2.
- o_valid = v2; o_color is the stage-2 register.
- Simultaneous input and output transfers in the same cycle are legal and preserve order.
- Channels are independent; no cross-channel carry.
- Unknown modes cannot occur (2-bit field fully decoded).

Decomposition:
- Shared package pixel_blend_pkg holds:
  - mode localparams MODE_BLEND=0, MODE_ADD=1, MODE_REPLACE=2, MODE_MULTIPLY=3;
  - the alpha-weight function;
  - width helper constants (PROD_W = COMP_W+ALPHA_W+1, MUL_W = 2*COMP_W+1).
- One natural sub-module, blend_channel_pipe: a single-channel, two-stage datapath with shared enables, generated NUM_CH times.
- Handshake and valid flags live in the top module.

Test Plan (default parameters, i_ready=1 unless stated):
- BLEND, bg=0x000, fg=0xF84:
  - a=4 -> 0x742 two cycles after accept.
  - a=7 -> 0xF84.
  - a=0 -> 0x000.
- ADD, a=7:
  - bg=0x888, fg=0xFFF -> 0xFFF (saturated).
  - bg=0x123, fg=0x111 -> 0x234.
  - bg=0x123, fg=0x111, a=0 -> 0x123.
- REPLACE and MULTIPLY:
  - REPLACE, bg=0xABC, fg=0x123: a=1 -> 0x123; a=0 -> 0xABC.
  - MULTIPLY, bg=0xF80, fg=0xF0F, any a -> 0xF00.
  - MULTIPLY, fg=0xFFF -> bg unchanged.
- Backpressure:
  - Stream 6 distinct pixels with i_valid=1 and random i_ready.
  - Outputs appear in order with none lost or duplicated.
  - o_color is stable while o_valid=1 and i_ready=0.
  - With both stages full and i_ready=0, o_ready=0.
- Reset mid-stream: assert i_rst_n=0 asynchronously with both stages full -> o_valid=0 and o_color=0 immediately. After release, the next accepted pixel emerges with 2-cycle latency.
- Full-throughput run: 100 back-to-back pixels with i_ready=1 -> o_valid stays continuously high from cycle 2, and every output matches the reference model.

Source files
------------

// File: rtl/pixel_blend_pkg.sv
// Shared definitions for the pixel blend pipeline: default widths, blend mode
// codes and the alpha-to-weight mapping.
package pixel_blend_pkg;

    localparam int unsigned DEF_COMP_W  = 4;
    localparam int unsigned DEF_NUM_CH  = 3;
    localparam int unsigned DEF_ALPHA_W = 3;

    localparam logic [1:0] MODE_BLEND    = 2'd0;
    localparam logic [1:0] MODE_ADD      = 2'd1;
    localparam logic [1:0] MODE_REPLACE  = 2'd2;
    localparam logic [1:0] MODE_MULTIPLY = 2'd3;

    function automatic int unsigned prod_width(input int unsigned comp_w,
                                               input int unsigned alpha_w);
        return comp_w + alpha_w + 1;
    endfunction

    function automatic int unsigned mul_width(input int unsigned comp_w);
        return 2 * comp_w + 1;
    endfunction

    localparam int unsigned PROD_W = DEF_COMP_W + DEF_ALPHA_W + 1;
    localparam int unsigned MUL_W  = 2 * DEF_COMP_W + 1;

    // The top alpha code maps to a full 2^ALPHA_W weight so that opaque
    // foreground reproduces fg exactly after the final shift.
    function automatic int unsigned alpha_weight(input int unsigned a,
                                                 input int unsigned alpha_w);
        int unsigned amax;
        amax = (32'd1 << alpha_w) - 32'd1;
        return (a == amax) ? amax + 32'd1 : a;
    endfunction

endpackage

// File: rtl/blend_channel_pipe.sv
// One colour channel of the blend pipeline: stage 1 forms the weighted
// products, stage 2 selects and saturates the result for the chosen mode.
module blend_channel_pipe
    import pixel_blend_pkg::*;
#(
    parameter int unsigned COMP_W  = DEF_COMP_W,
    parameter int unsigned ALPHA_W = DEF_ALPHA_W,
    parameter int unsigned PW      = PROD_W,
    parameter int unsigned MW      = MUL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en1,
    input  logic               en2,
    input  logic [COMP_W-1:0]  bg,
    input  logic [COMP_W-1:0]  fg,
    input  logic [ALPHA_W-1:0] alpha,
    input  logic [1:0]         mode,
    output logic [COMP_W-1:0]  color
);

    localparam logic [ALPHA_W:0]   W_FULL = {1'b1, {ALPHA_W{1'b0}}};
    localparam logic [PW:0]        CMAX_P = (PW+1)'((1 << COMP_W) - 1);
    localparam logic [MW-1:0]      CMAX_M = MW'((1 << COMP_W) - 1);
    localparam logic [COMP_W-1:0]  CMAX   = '1;

    logic [ALPHA_W:0]  w;
    logic [ALPHA_W:0]  w_q;
    logic [PW-1:0]     pf;
    logic [PW-1:0]     pb;
    logic [PW-1:0]     pf_q;
    logic [PW-1:0]     pb_q;
    logic [MW-1:0]     pm;
    logic [MW-1:0]     pm_q;
    logic [1:0]        mode_q;
    logic [COMP_W-1:0] bg_q;
    logic [COMP_W-1:0] fg_q;
    logic [PW:0]       blend_t;
    logic [PW:0]       add_t;
    logic [MW-1:0]     mul_t;
    logic [COMP_W-1:0] result;

    assign w  = (ALPHA_W+1)'(alpha_weight(32'(alpha), ALPHA_W));
    assign pf = {{(PW-COMP_W){1'b0}}, fg} * {{(PW-ALPHA_W-1){1'b0}}, w};
    assign pb = {{(PW-COMP_W){1'b0}}, bg} * {{(PW-ALPHA_W-1){1'b0}}, W_FULL - w};
    assign pm = {{(MW-COMP_W){1'b0}}, bg} * ({{(MW-COMP_W){1'b0}}, fg} + MW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            w_q    <= '0;
            pf_q   <= '0;
            pb_q   <= '0;
            pm_q   <= '0;
            bg_q   <= '0;
            fg_q   <= '0;
        end else if (en1) begin
            mode_q <= mode;
            w_q    <= w;
            pf_q   <= pf;
            pb_q   <= pb;
            pm_q   <= pm;
            bg_q   <= bg;
            fg_q   <= fg;
        end
    end

    // Blend and multiply cannot exceed CMAX; the clamp only keeps every
    // intermediate bit meaningful and guards odd parameter choices.
    always_comb begin
        blend_t = ({1'b0, pf_q} + {1'b0, pb_q}) >> ALPHA_W;
        add_t   = ({1'b0, pf_q} >> ALPHA_W) + {{(PW+1-COMP_W){1'b0}}, bg_q};
        mul_t   = pm_q >> COMP_W;
        result  = bg_q;
        case (mode_q)
            MODE_BLEND:    result = (blend_t > CMAX_P) ? CMAX : blend_t[COMP_W-1:0];
            MODE_ADD:      result = (add_t > CMAX_P) ? CMAX : add_t[COMP_W-1:0];
            MODE_REPLACE:  result = (w_q != '0) ? fg_q : bg_q;
            MODE_MULTIPLY: result = (mul_t > CMAX_M) ? CMAX : mul_t[COMP_W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color <= '0;
        end else if (en2) begin
            color <= result;
        end
    end

endmodule

// File: rtl/pixel_blend_pipe.sv
// Two-stage pipelined pixel blender with valid/ready on both sides; stalls
// from the line buffer propagate straight back to the pixel fetch.
module pixel_blend_pipe
    import pixel_blend_pkg::*;
#(
    parameter int unsigned COMP_W  = DEF_COMP_W,
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned ALPHA_W = DEF_ALPHA_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_CH*COMP_W-1:0] i_bg_color,
    input  logic [NUM_CH*COMP_W-1:0] i_fg_color,
    input  logic [ALPHA_W-1:0]       i_fg_alpha,
    input  logic [1:0]               i_mode,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_CH*COMP_W-1:0] o_color
);

    logic v1;
    logic v2;
    logic en1;
    logic en2;

    assign en2     = !v2 || i_ready;
    assign en1     = !v1 || en2;
    assign o_ready = en1;
    assign o_valid = v2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (en1) v1 <= i_valid;
            if (en2) v2 <= v1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        blend_channel_pipe #(
            .COMP_W  (COMP_W),
            .ALPHA_W (ALPHA_W),
            .PW      (prod_width(COMP_W, ALPHA_W)),
            .MW      (mul_width(COMP_W))
        ) u_ch (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .en1   (en1),
            .en2   (en2),
            .bg    (i_bg_color[ch*COMP_W +: COMP_W]),
            .fg    (i_fg_color[ch*COMP_W +: COMP_W]),
            .alpha (i_fg_alpha),
            .mode  (i_mode),
            .color (o_color[ch*COMP_W +: COMP_W])
        );
    end

endmodule
